scaler_step_ctrl: RTL and testbench

- Frame-synchronous configuration controller for the scaler pipeline (scaler_h, scaler_v).
- Host writes input/output width and height.
- The block computes the fixed-point step values (4.12 unsigned, STEP = 1.0) with a serial divider.
- It holds the results in shadow registers and applies both steps atomically on the next vs_i rising edge, so a frame never sees a mid-frame step change.

---
 rtl/scaler_pkg.sv | 9 +
 rtl/scaler_div.sv | 47 ++++
 rtl/scaler_step_ctrl.sv | 97 +++++++++
 tb/tb_scaler_step_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// scaler_pkg: shared defaults, quotient-width helper and FSM state type for the step controller.
package scaler_pkg;
    localparam int STEP_DEF = 4096;
    localparam int STEP_WIDTH_DEF = 16;
    typedef enum logic [1:0] {IDLE, DIV_H, DIV_V, PEND} state_t;
    function automatic int calc_qw(input int dim_width, input int step);
        return dim_width + $clog2(step);
    endfunction
endpackage

// File: rtl/scaler_div.sv
// scaler_div: serial restoring unsigned divider, one quotient bit per cycle.
// The start cycle already resolves the first bit, so done pulses exactly QW cycles after start.
module scaler_div #(
    parameter int DW = 16,
    parameter int QW = 28
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [QW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int CW = $clog2(QW);
    logic [DW-1:0] rem, den, src_r, src_d, nxt_r;
    logic [QW-1:0] quo, src_q;
    logic [DW:0]   trial;
    logic [CW-1:0] cnt;
    logic          ge;
    always_comb begin
        src_r = start ? '0 : rem;
        src_q = start ? dividend : quo;
        src_d = start ? divisor : den;
        trial = {src_r, src_q[QW-1]};
        ge    = trial >= {1'b0, src_d};
        nxt_r = ge ? DW'(trial - {1'b0, src_d}) : trial[DW-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            den  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= !start && cnt == CW'(1);
            if (start || cnt != '0) begin
                rem <= nxt_r;
                quo <= {src_q[QW-2:0], ge};
                den <= src_d;
                cnt <= start ? CW'(QW - 1) : cnt - CW'(1);
            end
        end
    end
    assign quotient = quo;
endmodule

// File: rtl/scaler_step_ctrl.sv
// scaler_step_ctrl: computes 4.12 scaler steps from host dimensions and applies both
// atomically on the first vsync rise after the divides finish.
module scaler_step_ctrl
    import scaler_pkg::*;
#(
    parameter int STEP       = STEP_DEF,
    parameter int DIM_WIDTH  = 16,
    parameter int STEP_WIDTH = STEP_WIDTH_DEF,
    parameter int STEP_INIT  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIM_WIDTH-1:0]  cfg_in_w,
    input  logic [DIM_WIDTH-1:0]  cfg_out_w,
    input  logic [DIM_WIDTH-1:0]  cfg_in_h,
    input  logic [DIM_WIDTH-1:0]  cfg_out_h,
    input  logic                  cfg_wr,
    input  logic                  vs_i,
    output logic [STEP_WIDTH-1:0] step_h_o,
    output logic [STEP_WIDTH-1:0] step_v_o,
    output logic                  upd_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  sat_o
);
    localparam int LOG = $clog2(STEP);
    localparam int QW  = calc_qw(DIM_WIDTH, STEP);
    state_t                state;
    logic                  vs_q, rise, zero, start, done, ovf;
    logic [DIM_WIDTH-1:0]  in_h, out_h, divisor;
    logic [QW-1:0]         dividend, quotient;
    logic [STEP_WIDTH-1:0] shadow_h, shadow_v, clamped;
    assign rise     = vs_i & ~vs_q;
    assign zero     = cfg_in_w == '0 || cfg_out_w == '0 || cfg_in_h == '0 || cfg_out_h == '0;
    assign ovf      = |quotient[QW-1:STEP_WIDTH];
    assign clamped  = ovf ? '1 : quotient[STEP_WIDTH-1:0];
    // Width divide launches straight from the cfg inputs; height reuses the divider from latched values.
    assign start    = state == IDLE ? cfg_wr && !zero : state == DIV_H && done;
    assign dividend = {state == IDLE ? cfg_in_w : in_h, {LOG{1'b0}}};
    assign divisor  = state == IDLE ? cfg_out_w : out_h;
    scaler_div #(.DW(DIM_WIDTH), .QW(QW)) u_div (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .done(done),
        .quotient(quotient)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vs_q     <= 1'b0;
            in_h     <= '0;
            out_h    <= '0;
            shadow_h <= STEP_WIDTH'(STEP_INIT);
            shadow_v <= STEP_WIDTH'(STEP_INIT);
            step_h_o <= STEP_WIDTH'(STEP_INIT);
            step_v_o <= STEP_WIDTH'(STEP_INIT);
            upd_o    <= 1'b0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
            sat_o    <= 1'b0;
        end else begin
            vs_q  <= vs_i;
            upd_o <= 1'b0;
            case (state)
                IDLE: if (cfg_wr) begin
                    in_h   <= cfg_in_h;
                    out_h  <= cfg_out_h;
                    err_o  <= zero;
                    sat_o  <= 1'b0;
                    busy_o <= !zero;
                    state  <= zero ? IDLE : DIV_H;
                end
                DIV_H: if (done) begin
                    shadow_h <= clamped;
                    sat_o    <= sat_o | ovf;
                    state    <= DIV_V;
                end
                DIV_V: if (done) begin
                    shadow_v <= clamped;
                    sat_o    <= sat_o | ovf;
                    state    <= PEND;
                end
                PEND: if (rise) begin
                    step_h_o <= shadow_h;
                    step_v_o <= shadow_v;
                    upd_o    <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scaler_step_ctrl.sv
// tb_scaler_step_ctrl: directed stimulus with a step-pair scoreboard checked on every upd_o pulse.
module tb_scaler_step_ctrl;
    logic        clk = 1'b0, rst = 1'b1, cfg_wr = 1'b0, vs_i = 1'b0;
    logic [15:0] cfg_in_w = '0, cfg_out_w = '0, cfg_in_h = '0, cfg_out_h = '0;
    logic [15:0] step_h_o, step_v_o;
    logic        upd_o, busy_o, err_o, sat_o;
    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic        flag;

    always #5 clk = ~clk;

    scaler_step_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_in_w(cfg_in_w), .cfg_out_w(cfg_out_w), .cfg_in_h(cfg_in_h), .cfg_out_h(cfg_out_h),
        .cfg_wr(cfg_wr), .vs_i(vs_i),
        .step_h_o(step_h_o), .step_v_o(step_v_o),
        .upd_o(upd_o), .busy_o(busy_o), .err_o(err_o), .sat_o(sat_o)
    );

    always @(negedge clk) begin
        if (!rst && upd_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL upd_unexpected: got upd with step_h=%0d step_v=%0d, want no upd", step_h_o, step_v_o);
            end else begin
                e = exp_q.pop_front();
                if ({step_h_o, step_v_o} !== e) begin
                    bad++;
                    $display("FAIL apply_steps: got h=%0d v=%0d want h=%0d v=%0d",
                             step_h_o, step_v_o, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic write(input int iw, input int ow, input int ih, input int oh);
        tick();
        cfg_in_w = 16'(iw); cfg_out_w = 16'(ow); cfg_in_h = 16'(ih); cfg_out_h = 16'(oh);
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic vs_pulse(input string name, input bit want);
        bit seen;
        seen = 1'b0;
        vs_i = 1'b1;
        for (int i = 0; i < 8 && !(seen && want); i++) begin
            tick();
            vs_i = 1'b0;
            @(negedge clk);
            if (upd_o) seen = 1'b1;
        end
        chk(name, int'(seen), int'(want));
    endtask

    task automatic push(input int h, input int v);
        exp_q.push_back({16'(h), 16'(v)});
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_step_h", step_h_o, 4096);
        chk("rst_step_v", step_v_o, 4096);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_upd", upd_o, 0);

        // 1: halve both dimensions, apply long after the divides finish
        write(25, 50, 25, 50);
        push(2048, 2048);
        flag = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o || upd_o) flag = 1'b0;
            tick();
        end
        chk("busy_hold", int'(flag), 1);
        vs_pulse("apply1", 1'b1);
        tick();
        @(negedge clk);
        chk("busy_after_apply1", busy_o, 0);

        // 2: rise in cycle 56 is still mid-divide; rise in cycle 58 applies in 59
        write(600, 300, 25, 3);
        push(8192, 34133);
        repeat (55) tick();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        @(negedge clk);
        chk("upd_c57", upd_o, 0);
        tick();
        vs_i = 1'b1;
        @(negedge clk);
        chk("upd_c58", upd_o, 0);
        tick();
        vs_i = 1'b0;
        @(negedge clk);
        chk("upd_c59", upd_o, 1);

        // 3: saturation, then cleared by the next valid write
        write(4096, 1, 1, 1);
        push(65535, 4096);
        repeat (60) tick();
        @(negedge clk);
        chk("sat_set", sat_o, 1);
        chk("busy_pend", busy_o, 1);
        vs_pulse("apply_sat", 1'b1);
        chk("sat_kept", sat_o, 1);
        write(25, 50, 25, 50);
        push(2048, 2048);
        @(negedge clk);
        chk("sat_cleared", sat_o, 0);
        repeat (60) tick();
        vs_pulse("apply3", 1'b1);

        // 4: zero dimension
        write(100, 50, 100, 0);
        @(negedge clk);
        chk("err_set", err_o, 1);
        chk("err_busy", busy_o, 0);
        repeat (60) tick();
        vs_pulse("err_no_upd", 1'b0);
        chk("err_step_h", step_h_o, 2048);
        chk("err_step_v", step_v_o, 2048);

        // 5: rise during DIV_H ignored, second write during busy dropped
        write(50, 25, 50, 100);
        push(8192, 2048);
        @(negedge clk);
        chk("err_cleared", err_o, 0);
        repeat (19) tick();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        repeat (9) tick();
        cfg_in_w = 16'd1; cfg_out_w = 16'd1; cfg_in_h = 16'd1; cfg_out_h = 16'd1;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        @(negedge clk);
        chk("busy_drop", busy_o, 1);
        repeat (40) tick();
        vs_pulse("apply_first_cfg", 1'b1);
        chk("err_after_drop", err_o, 0);

        // 5b: cfg_wr and rise together in PEND: rise wins, write dropped
        write(25, 50, 25, 50);
        push(2048, 2048);
        repeat (70) tick();
        cfg_in_w = 16'd1; cfg_out_w = 16'd1; cfg_in_h = 16'd1; cfg_out_h = 16'd1;
        cfg_wr = 1'b1;
        vs_i = 1'b1;
        tick();
        cfg_wr = 1'b0;
        vs_i = 1'b0;
        @(negedge clk);
        chk("upd_same_cycle", upd_o, 1);
        tick();
        @(negedge clk);
        chk("busy_same_cycle", busy_o, 0);
        repeat (70) tick();
        vs_pulse("no_apply_dropped", 1'b0);
        chk("step_h_kept", step_h_o, 2048);

        // 6: reset while pending
        write(600, 300, 25, 3);
        repeat (70) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pend_step_h", step_h_o, 4096);
        chk("rst_pend_step_v", step_v_o, 4096);
        chk("rst_pend_busy", busy_o, 0);
        vs_pulse("rst_pend_no_upd", 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
